// File: rtl/airi5c_alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice: ALU opcodes, grant and slot encodings.
package airi5c_alu_arbiter_pkg;

   localparam int ALU_OP_WIDTH = 4;
   localparam int XPR_LEN_DEF  = 32;

   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'd0;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'd1;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'd4;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'd5;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'd6;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'd7;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SEQ  = 4'd8;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SNE  = 4'd9;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'd10;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'd11;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'd12;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGE  = 4'd13;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'd14;
   localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SGEU = 4'd15;

   typedef enum logic {
      GRANT_P0 = 1'b0,
      GRANT_P1 = 1'b1
   } grant_e;

   typedef enum logic {
      RSP_SLOT_EMPTY = 1'b0,
      RSP_SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/airi5c_alu.sv
// Combinational integer ALU; undefined opcodes produce zero.
module airi5c_alu
   import airi5c_alu_arbiter_pkg::*;
#(
   parameter int XPR_LEN = XPR_LEN_DEF,
   parameter int OP_W    = ALU_OP_WIDTH
) (
   input  logic [OP_W-1:0]    op,
   input  logic [XPR_LEN-1:0] in1,
   input  logic [XPR_LEN-1:0] in2,
   output logic [XPR_LEN-1:0] out
);

   localparam int SHW = $clog2(XPR_LEN);

   logic [SHW-1:0] shamt;
   logic           lt_s;
   logic           lt_u;

   assign shamt = in2[SHW-1:0];
   assign lt_s  = $signed(in1) < $signed(in2);
   assign lt_u  = in1 < in2;

   always_comb begin
      out = '0;
      case (op)
         OP_W'(ALU_OP_ADD):  out = in1 + in2;
         OP_W'(ALU_OP_SUB):  out = in1 - in2;
         OP_W'(ALU_OP_SLL):  out = in1 << shamt;
         OP_W'(ALU_OP_SRL):  out = in1 >> shamt;
         OP_W'(ALU_OP_SRA):  out = XPR_LEN'($signed(in1) >>> shamt);
         OP_W'(ALU_OP_XOR):  out = in1 ^ in2;
         OP_W'(ALU_OP_OR):   out = in1 | in2;
         OP_W'(ALU_OP_AND):  out = in1 & in2;
         OP_W'(ALU_OP_SEQ):  out = XPR_LEN'(in1 == in2);
         OP_W'(ALU_OP_SNE):  out = XPR_LEN'(in1 != in2);
         OP_W'(ALU_OP_SLT):  out = XPR_LEN'(lt_s);
         OP_W'(ALU_OP_SGE):  out = XPR_LEN'(!lt_s);
         OP_W'(ALU_OP_SLTU): out = XPR_LEN'(lt_u);
         OP_W'(ALU_OP_SGEU): out = XPR_LEN'(!lt_u);
         default:            out = '0;
      endcase
   end

endmodule

// File: rtl/airi5c_alu_rsp_slot.sv
// One-entry result+tag holding register with load/drain handshake.
module airi5c_alu_rsp_slot
   import airi5c_alu_arbiter_pkg::*;
#(
   parameter int DATA_W = XPR_LEN_DEF,
   parameter int TAG_W  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [TAG_W-1:0]  tag_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic [TAG_W-1:0]  tag_o
);

   slot_state_e       state_reg, state_next;
   logic [DATA_W-1:0] data_reg;
   logic [TAG_W-1:0]  tag_reg;

   // A load in the same cycle as a drain keeps the slot full with the new result.
   always_comb begin
      state_next = state_reg;
      if (load_i)
         state_next = RSP_SLOT_FULL;
      else if (ready_i)
         state_next = RSP_SLOT_EMPTY;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_reg <= RSP_SLOT_EMPTY;
         data_reg  <= '0;
         tag_reg   <= '0;
      end else begin
         state_reg <= state_next;
         if (load_i) begin
            data_reg <= data_i;
            tag_reg  <= tag_i;
         end
      end
   end

   assign valid_o = (state_reg == RSP_SLOT_FULL);
   assign data_o  = data_reg;
   assign tag_o   = tag_reg;

endmodule

// File: rtl/airi5c_alu_arbiter.sv
// Shares a single ALU between the execute stage (port 0) and an auxiliary unit (port 1).
module airi5c_alu_arbiter
   import airi5c_alu_arbiter_pkg::*;
#(
   parameter bit RR_EN   = 1'b1,
   parameter int TAG_W   = 3,
   parameter int XPR_LEN = XPR_LEN_DEF,
   parameter int OP_W    = ALU_OP_WIDTH
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               req0_valid_i,
   output logic               req0_ready_o,
   input  logic [OP_W-1:0]    req0_op_i,
   input  logic [XPR_LEN-1:0] req0_in1_i,
   input  logic [XPR_LEN-1:0] req0_in2_i,
   input  logic [TAG_W-1:0]   req0_tag_i,
   output logic               rsp0_valid_o,
   input  logic               rsp0_ready_i,
   output logic [XPR_LEN-1:0] rsp0_result_o,
   output logic [TAG_W-1:0]   rsp0_tag_o,
   input  logic               req1_valid_i,
   output logic               req1_ready_o,
   input  logic [OP_W-1:0]    req1_op_i,
   input  logic [XPR_LEN-1:0] req1_in1_i,
   input  logic [XPR_LEN-1:0] req1_in2_i,
   input  logic [TAG_W-1:0]   req1_tag_i,
   output logic               rsp1_valid_o,
   input  logic               rsp1_ready_i,
   output logic [XPR_LEN-1:0] rsp1_result_o,
   output logic [TAG_W-1:0]   rsp1_tag_o,
   output logic               busy_o
);

   grant_e             last_grant_reg, last_grant_next;
   logic               cand0, cand1;
   logic               grant0, grant1;
   logic [OP_W-1:0]    alu_op;
   logic [XPR_LEN-1:0] alu_in1, alu_in2, alu_out;
   logic [TAG_W-1:0]   grant_tag;

   // A full slot is eligible only if it drains this same cycle.
   assign cand0 = rst_ni && req0_valid_i && (!rsp0_valid_o || rsp0_ready_i);
   assign cand1 = rst_ni && req1_valid_i && (!rsp1_valid_o || rsp1_ready_i);

   always_comb begin
      grant0          = 1'b0;
      grant1          = 1'b0;
      last_grant_next = last_grant_reg;
      if (cand0 && cand1) begin
         if (RR_EN && last_grant_reg == GRANT_P0)
            grant1 = 1'b1;
         else
            grant0 = 1'b1;
      end else begin
         grant0 = cand0;
         grant1 = cand1;
      end
      if (grant0)
         last_grant_next = GRANT_P0;
      else if (grant1)
         last_grant_next = GRANT_P1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni)
         last_grant_reg <= GRANT_P1;
      else
         last_grant_reg <= last_grant_next;
   end

   // Quiet ALU inputs when idle.
   always_comb begin
      alu_op    = OP_W'(ALU_OP_ADD);
      alu_in1   = '0;
      alu_in2   = '0;
      grant_tag = '0;
      if (grant0) begin
         alu_op    = req0_op_i;
         alu_in1   = req0_in1_i;
         alu_in2   = req0_in2_i;
         grant_tag = req0_tag_i;
      end else if (grant1) begin
         alu_op    = req1_op_i;
         alu_in1   = req1_in1_i;
         alu_in2   = req1_in2_i;
         grant_tag = req1_tag_i;
      end
   end

   airi5c_alu #(.XPR_LEN(XPR_LEN), .OP_W(OP_W)) u_alu (
      .op  (alu_op),
      .in1 (alu_in1),
      .in2 (alu_in2),
      .out (alu_out)
   );

   airi5c_alu_rsp_slot #(.DATA_W(XPR_LEN), .TAG_W(TAG_W)) u_slot0 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (grant0),
      .data_i  (alu_out),
      .tag_i   (grant_tag),
      .ready_i (rsp0_ready_i),
      .valid_o (rsp0_valid_o),
      .data_o  (rsp0_result_o),
      .tag_o   (rsp0_tag_o)
   );

   airi5c_alu_rsp_slot #(.DATA_W(XPR_LEN), .TAG_W(TAG_W)) u_slot1 (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .load_i  (grant1),
      .data_i  (alu_out),
      .tag_i   (grant_tag),
      .ready_i (rsp1_ready_i),
      .valid_o (rsp1_valid_o),
      .data_o  (rsp1_result_o),
      .tag_o   (rsp1_tag_o)
   );

   assign req0_ready_o = grant0;
   assign req1_ready_o = grant1;
   assign busy_o       = rsp0_valid_o | rsp1_valid_o;

endmodule
